// File: rtl/gameover_banner_ctrl_if.sv
// gameover_banner_ctrl_if: frame/pixel scan inputs and banner hit-test outputs
interface gameover_banner_ctrl_if;
   logic        startOfFrame;
   logic        gameOver;
   logic        restart;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        InsideRectangle;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        bannerActive;
   logic        bannerSettled;
   modport master (
      output startOfFrame, gameOver, restart, pixelX, pixelY,
      input  InsideRectangle, offsetX, offsetY, bannerActive, bannerSettled
   );
   modport slave (
      input  startOfFrame, gameOver, restart, pixelX, pixelY,
      output InsideRectangle, offsetX, offsetY, bannerActive, bannerSettled
   );
endinterface

// File: rtl/gameover_banner_ctrl.sv
// gameover_banner_ctrl: slides the GAME OVER banner into place, blinks it, and hit-tests each pixel
module gameover_banner_ctrl #(
   parameter int BANNER_W     = 140,
   parameter int BANNER_H     = 24,
   parameter int TARGET_X     = 250,
   parameter int TARGET_Y     = 228,
   parameter int START_Y      = 0,
   parameter int SPEED        = 4,
   parameter int BLINK_FRAMES = 30
) (
   input logic                   clk,
   input logic                   resetN,
   gameover_banner_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SLIDE, SHOW} state_t;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [11:0] TX   = 12'(TARGET_X);
   localparam logic [11:0] TXE  = 12'(TARGET_X + BANNER_W);
   localparam logic [11:0] TY   = 12'(TARGET_Y);
   localparam logic [11:0] SP   = 12'(SPEED);
   localparam logic [11:0] BH   = 12'(BANNER_H);
   localparam logic [10:0] TX11 = 11'(TARGET_X);
   localparam logic [10:0] TY11 = 11'(TARGET_Y);
   localparam logic [10:0] SY11 = 11'(START_Y);
   localparam logic [BW-1:0] BL = BW'(BLINK_FRAMES - 1);
   state_t          state_q;
   logic [10:0]     top_y_q;
   logic            visible_q;
   logic [BW-1:0]   blink_q;
   logic            inside_q, active_q, settled_q;
   logic [10:0]     off_x_q, off_y_q;
   logic [11:0]     px_d, py_d, top_d, step_d;
   logic            hit_d;
   assign px_d   = {1'b0, bus.pixelX};
   assign py_d   = {1'b0, bus.pixelY};
   assign top_d  = {1'b0, top_y_q};
   // 12-bit sums so neither the slide step nor the bottom edge can wrap
   assign step_d = top_d + SP;
   assign hit_d  = visible_q && px_d >= TX && px_d < TXE && py_d >= top_d && py_d < top_d + BH;
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         top_y_q   <= SY11;
         visible_q <= 1'b0;
         blink_q   <= '0;
         inside_q  <= 1'b0;
         off_x_q   <= '0;
         off_y_q   <= '0;
         active_q  <= 1'b0;
         settled_q <= 1'b0;
      end else begin
         if (bus.restart) begin
            state_q   <= IDLE;
            top_y_q   <= SY11;
            visible_q <= 1'b0;
            blink_q   <= '0;
         end else begin
            case (state_q)
               IDLE: if (bus.gameOver) begin
                  state_q   <= SLIDE;
                  top_y_q   <= SY11;
                  visible_q <= 1'b1;
               end
               SLIDE: if (bus.startOfFrame) begin
                  if (step_d >= TY) begin
                     state_q   <= SHOW;
                     top_y_q   <= TY11;
                     blink_q   <= '0;
                     visible_q <= 1'b1;
                  end else top_y_q <= step_d[10:0];
               end
               SHOW: if (bus.startOfFrame) begin
                  if (blink_q == BL) begin
                     visible_q <= ~visible_q;
                     blink_q   <= '0;
                  end else blink_q <= blink_q + 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
         inside_q  <= hit_d;
         off_x_q   <= hit_d ? bus.pixelX - TX11 : '0;
         off_y_q   <= hit_d ? bus.pixelY - top_y_q : '0;
         active_q  <= state_q != IDLE;
         settled_q <= state_q == SHOW;
      end
   end
   assign bus.InsideRectangle = inside_q;
   assign bus.offsetX         = off_x_q;
   assign bus.offsetY         = off_y_q;
   assign bus.bannerActive    = active_q;
   assign bus.bannerSettled   = settled_q;
endmodule

// File: doc/gameover_banner_ctrl.md
# gameover_banner_ctrl

Drives the "GAME OVER" banner bitmap. On a game-over event it slides the banner down from the top of the screen to a fixed rest position, then blinks it at a fixed frame rate. It runs until a restart clears it. For every scanned pixel it produces the registered `InsideRectangle`, `offsetX` and `offsetY` that the banner bitmap drawer consumes. The block sits between the VGA pixel scanner and the banner bitmap.

## Interface
Parameters:
- `BANNER_W`, default 140: on-screen width in pixels (bitmap 70 columns × 2).
- `BANNER_H`, default 24: on-screen height in pixels (bitmap 12 rows × 2).
- `TARGET_X`, default 250: fixed left edge, `(640-140)/2`.
- `TARGET_Y`, default 228: resting top edge.
- `START_Y`, default 0: top edge at slide start. Must satisfy `0 ≤ START_Y < TARGET_Y`.
- `SPEED`, default 4: pixels moved per frame while sliding. Must be ≥ 1.
- `BLINK_FRAMES`, default 30: frames per blink half-period. Must be ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle pulse per video frame.
- `gameOver`, in, 1: one-cycle pulse requesting the banner.
- `restart`, in, 1: one-cycle pulse that clears the banner.
- `pixelX`, in, 11: current scan column (unsigned).
- `pixelY`, in, 11: current scan row (unsigned).
- `InsideRectangle`, out, 1: pixel is inside the visible banner.
- `offsetX`, out, 11: `pixelX - TARGET_X` when inside, else 0.
- `offsetY`, out, 11: `pixelY - topY` when inside, else 0.
- `bannerActive`, out, 1: state is not IDLE.
- `bannerSettled`, out, 1: state is SHOW.

## Operation
- Internal state:
  - `state` ∈ {IDLE, SLIDE, SHOW}.
  - `topY`: 11-bit unsigned.
  - `visible`: 1 bit.
  - `blinkCnt`: wide enough for `BLINK_FRAMES-1`.
- IDLE:
  - `visible=0`.
  - `gameOver` → SLIDE, `topY=START_Y`, `visible=1`.
- SLIDE: on each `startOfFrame`:
  - if `topY+SPEED ≥ TARGET_Y`: `topY=TARGET_Y`, go to SHOW, `blinkCnt=0`, `visible=1`;
  - else `topY += SPEED`.
  - The sum is computed at 12 bits, so it cannot wrap.
- SHOW: on each `startOfFrame`:
  - if `blinkCnt == BLINK_FRAMES-1`: toggle `visible`, `blinkCnt=0`;
  - else increment `blinkCnt`.
- `restart` in any state → IDLE, `visible=0`, `topY=START_Y`, `blinkCnt=0`.
- Priority:
  - `restart` beats `gameOver` and `startOfFrame` in the same cycle.
  - `gameOver` outside IDLE is ignored and does not restart the slide.
  - `gameOver` together with `startOfFrame` in IDLE enters SLIDE with `topY=START_Y`. No motion is applied in that cycle.
- Position, state and `visible` change only on `startOfFrame` (apart from the `gameOver`/`restart` transitions), so no frame shows tearing.
- Hit test:
  - inside = `visible`
  - && `TARGET_X ≤ pixelX < TARGET_X+BANNER_W`
  - && `topY ≤ pixelY < topY+BANNER_H`.
  - Compare at 12 bits.

## Timing
- Reset (asynchronous): state IDLE, `topY=START_Y`, `visible=0`, `blinkCnt=0`. All outputs are 0.
- Hit-test outputs are registered with 1-cycle latency from `pixelX`/`pixelY`. The downstream bitmap adds its own 1 cycle.
- Hit-test outputs use the `topY`/`visible` values held during the sampling cycle.
- `bannerActive` and `bannerSettled` are registered and follow `state` one cycle after a transition.
- Slide duration = `ceil((TARGET_Y-START_Y)/SPEED)` frames. Defaults: 57 frames.
- Blink period = `2*BLINK_FRAMES` frames. Defaults: 30 frames on, 30 off.
- Reset asserted mid-slide or mid-blink: outputs go to 0 immediately. The block stays idle after release until the next `gameOver`.

## Test plan
- Reset, then scan a full 640×480 frame with no `gameOver` → `InsideRectangle=0` on every pixel; `bannerActive=0`.
- `gameOver`, then 1 frame tick → `topY=4`.
  - Pixel (250,4) → next cycle `InsideRectangle=1`, `offsetX=0`, `offsetY=0`.
  - Pixel (389,27) → `offsetX=139`, `offsetY=23`.
  - Pixel (390,4) → 0. Pixel (249,4) → 0.
- Apply 57 frame ticks after `gameOver` → `topY=228`, `bannerSettled=1`.
  - Pixel (250,228) → inside.
  - Pixel (250,252) → outside.
- In SHOW, 30 ticks → `visible=0`; pixel (300,240) → 0. 30 more ticks → visible again.
- `restart` and `gameOver` in the same cycle during SHOW → IDLE, all outputs 0.
  - A later `gameOver` in IDLE → fresh slide from `topY=0`.
- Second `gameOver` mid-SLIDE at `topY=100` → ignored; the next tick gives `topY=104`.
- `resetN` low mid-SLIDE → outputs 0 within the same cycle; the block stays IDLE after release.
